// File: rtl/sw_debounce_sel.sv
// -----------------------------------------------------------------------------
// sw_debounce_sel
// Debounces raw board switches/buttons into clean select levels for the
// downstream 2-to-1 mux stage. Each channel has a 2-FF synchroniser, a
// stability counter and registered one-cycle rise/fall event pulses.
//
// Parameters:
//   WIDTH      number of independent switch channels (>=1)
//   DB_CYCLES  consecutive mismatched cycles needed to accept a change (>=1)
//   RST_VAL    WIDTH-bit reset value of sync FFs, debounced level and select
//
// Ports:
//   i_clk       in   1      single clock, rising edge
//   i_rst_n     in   1      synchronous active-low reset
//   i_sw_raw    in   WIDTH  raw asynchronous switch inputs
//   o_db_level  out  WIDTH  debounced level per channel
//   o_sel       out  WIDTH  select to mux stage
//   o_rise      out  WIDTH  one-cycle pulse on debounced 0->1
//   o_fall      out  WIDTH  one-cycle pulse on debounced 1->0
//   o_stable    out  1      every channel idle and synchronised input settled
//
// Optional feature (macro SEL_TOGGLE_EN):
//   defined   : o_sel is its own register, toggling on each rise pulse
//               (push-button toggle behaviour).
//   undefined : o_sel is wired straight to o_db_level.
//
// Per-channel FSM:
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | synchronised input agrees with debounced level, count 0
//   ST_CHECK | input differs; counting consecutive mismatched cycles
// -----------------------------------------------------------------------------
module sw_debounce_sel #(
    parameter int                WIDTH     = 2,
    parameter int                DB_CYCLES = 4,
    parameter logic [WIDTH-1:0]  RST_VAL   = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_sw_raw,
    output logic [WIDTH-1:0] o_db_level,
    output logic [WIDTH-1:0] o_sel,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic             o_stable
);

    localparam int            CW   = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_ch_stable;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
        end else begin
            r_sync1 <= i_sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        state_t        r_state;
        state_t        w_state_nxt;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nxt;
        logic          r_db;
        logic          r_rise;
        logic          r_fall;
        logic          w_diff;
        logic          w_accept;

        assign w_diff = r_sync2[g] ^ r_db;

        // State register
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // Next-state logic; with DB_CYCLES==1 a mismatch is accepted
        // straight from IDLE, so CHECK is never entered.
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_diff && (DB_CYCLES > 1)) begin
                        w_state_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!w_diff || (r_cnt == LAST)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        // Output / datapath logic: counter update and accept decision.
        // The counter stops at LAST because reaching it always accepts.
        always_comb begin
            w_cnt_nxt = '0;
            w_accept  = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_diff) begin
                        if (DB_CYCLES == 1) begin
                            w_accept = 1'b1;
                        end else begin
                            w_cnt_nxt = CW'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_diff) begin
                        if (r_cnt == LAST) begin
                            w_accept = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    w_cnt_nxt = '0;
                    w_accept  = 1'b0;
                end
            endcase
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_cnt  <= '0;
                r_db   <= RST_VAL[g];
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_nxt;
                r_rise <= w_accept & r_sync2[g];
                r_fall <= w_accept & ~r_sync2[g];
                if (w_accept) begin
                    r_db <= r_sync2[g];
                end
            end
        end

`ifdef SEL_TOGGLE_EN
        logic r_sel;

        // Toggle on the same edge the rise pulse is registered.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_sel <= RST_VAL[g];
            end else if (w_accept && r_sync2[g]) begin
                r_sel <= ~r_sel;
            end
        end

        assign o_sel[g] = r_sel;
`else
        assign o_sel[g] = r_db;
`endif

        assign o_db_level[g]  = r_db;
        assign o_rise[g]      = r_rise;
        assign o_fall[g]      = r_fall;
        assign w_ch_stable[g] = (r_state == ST_IDLE) && !w_diff;
    end

    assign o_stable = &w_ch_stable;

endmodule

// File: tb/tb_sw_debounce_sel.sv
module tb_sw_debounce_sel;

    localparam int               WIDTH = 2;
    localparam int               DB    = 4;
    localparam logic [WIDTH-1:0] RSTV  = '0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] db_level, sel, rise, fall;
    logic             stable;

    sw_debounce_sel #(.WIDTH(WIDTH), .DB_CYCLES(DB), .RST_VAL(RSTV)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sw_raw   (sw_raw),
        .o_db_level (db_level),
        .o_sel      (sel),
        .o_rise     (rise),
        .o_fall     (fall),
        .o_stable   (stable)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] db;
        logic [WIDTH-1:0] sel;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        logic             stable;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: a change is accepted once the last DB synchronised
    // samples all disagree with the current debounced level.
    logic [WIDTH-1:0] m_s1, m_s2, m_db, m_sel, m_rise, m_fall;
    logic             m_hist [WIDTH][DB];
    int               m_hcnt [WIDTH];

    always @(posedge clk) begin
        exp_t e;
        logic all_diff;
        logic stab;
        if (!rst_n) begin
            m_s1 = RSTV; m_s2 = RSTV; m_db = RSTV; m_sel = RSTV;
            m_rise = '0; m_fall = '0;
            for (int c = 0; c < WIDTH; c++) m_hcnt[c] = 0;
        end else begin
            for (int c = 0; c < WIDTH; c++) begin
                for (int k = DB - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
                m_hist[c][0] = m_s2[c];
                if (m_hcnt[c] < DB) m_hcnt[c]++;
                all_diff = (m_hcnt[c] == DB);
                for (int k = 0; k < DB; k++)
                    if (m_hist[c][k] == m_db[c]) all_diff = 1'b0;
                m_rise[c] = all_diff && m_s2[c];
                m_fall[c] = all_diff && !m_s2[c];
                if (all_diff) m_db[c] = m_s2[c];
`ifdef SEL_TOGGLE_EN
                if (m_rise[c]) m_sel[c] = ~m_sel[c];
`else
                m_sel[c] = m_db[c];
`endif
            end
            m_s2 = m_s1;
            m_s1 = sw_raw;
        end
        stab = 1'b1;
        for (int c = 0; c < WIDTH; c++) begin
            if (m_s2[c] != m_db[c]) stab = 1'b0;
            if (m_hcnt[c] > 0 && m_hist[c][0] != m_db[c]) stab = 1'b0;
        end
        e.db = m_db; e.sel = m_sel; e.rise = m_rise; e.fall = m_fall; e.stable = stab;
        sb.push_back(e);
    end

    // Monitor: outputs are settled by the falling edge.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a.db = db_level; a.sel = sel; a.rise = rise; a.fall = fall; a.stable = stable;
            n_checks++;
            if (a !== e) begin
                $display("FAIL outputs t=%0t: got db=%b sel=%b rise=%b fall=%b stable=%b, want db=%b sel=%b rise=%b fall=%b stable=%b",
                         $time, a.db, a.sel, a.rise, a.fall, a.stable,
                         e.db, e.sel, e.rise, e.fall, e.stable);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic step(input logic [WIDTH-1:0] raw, input logic rst, input int n);
        repeat (n) begin
            @(negedge clk);
            sw_raw = raw;
            rst_n  = rst;
        end
    endtask

    initial begin
        int len;
        logic [WIDTH-1:0] v;
        rst_n  = 1'b0;
        sw_raw = 2'b11;
        // reset held with inputs high, then release
        step(2'b11, 1'b0, 3);
        step(2'b11, 1'b1, 10);
        step(2'b00, 1'b0, 2);
        step(2'b00, 1'b1, 8);
        // clean press on ch0
        step(2'b01, 1'b1, 10);
        // bounce on ch1, then held high
        for (int i = 0; i < 10; i++) step({i[0], 1'b1}, 1'b1, 1);
        step(2'b11, 1'b1, 10);
        // glitches shorter than the debounce window
        step(2'b00, 1'b1, 10);
        step(2'b01, 1'b1, 3);
        step(2'b00, 1'b1, 10);
        // reset mid-count
        step(2'b01, 1'b1, 3);
        step(2'b01, 1'b0, 1);
        step(2'b01, 1'b1, 10);
        // two press/release cycles on ch0
        step(2'b00, 1'b1, 8);
        step(2'b01, 1'b1, 8);
        step(2'b00, 1'b1, 8);
        step(2'b01, 1'b1, 8);
        step(2'b00, 1'b1, 8);
        // randomized holds and bounces, occasional reset
        for (int i = 0; i < 400; i++) begin
            v   = WIDTH'($urandom_range(0, 3));
            len = $urandom_range(1, 8);
            step(v, ($urandom_range(0, 40) == 0) ? 1'b0 : 1'b1, 1);
            if (len > 1) step(v, 1'b1, len - 1);
        end
        step(2'b00, 1'b1, 10);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
